// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared types and constants for the NPU memory responder
// Holds the responder state encoding, the legal READ_LATENCY bounds, the
// access-counter width and a saturating increment helper.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/npu_sram_1rw.sv
// rtl/npu_sram_1rw.sv - single-port synchronous word storage
// Ports: clk; en enables one access per cycle; we selects write (else read);
// addr word index; wdata write word; rdata read word, updated one edge after
// a read and held otherwise. Contents have no reset.
module npu_sram_1rw #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/npu_mem_responder.sv
// rtl/npu_mem_responder.sv - memory responder for an NPU initiator port
// Ports: clk, rst_n (async active-low); mem_addr/mem_wdata/mem_we/mem_re
// level-held request from the initiator; mem_rdata read word and
// mem_mem_ready one-cycle completion strobe back to it; busy while a
// transaction is in flight; err sticky error with err_clr; rd_count and
// wr_count saturating completed-access counters.
module npu_mem_responder
  import npu_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int          READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_we,
  input  logic                  mem_re,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_mem_ready,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count
);

  // Latency values outside the supported range are clamped into it.
  localparam int RL = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                      (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [2:0]            LAT_LAST = 3'(RL - 1);

  state_t                state;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  oor_q;
  logic [2:0]            lat_cnt;
  logic                  is_wr_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic [CNT_W-1:0]      wr_cnt_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  oor;
  logic                  accept;
  logic                  err_event;
  logic                  sram_en;
  logic                  sram_we;
  logic [IDX_W-1:0]      sram_addr;
  logic [DATA_WIDTH-1:0] sram_rdata;

  // The below-base test guards the subtraction, so a wrapped offset is never
  // mistaken for a valid index.
  assign offset    = mem_addr - BASE_A;
  assign word_idx  = offset >> 2;
  assign oor       = (mem_addr < BASE_A) || (word_idx >= DEPTH_A);
  assign accept    = (state == ST_IDLE) && (mem_we || mem_re);
  assign err_event = accept && ((mem_we && mem_re) || (mem_addr[1:0] != 2'b00) || oor);

  // Reads are launched on the acceptance edge straight from mem_addr, so the
  // array output is already stable for every READ_WAIT cycle, including
  // READ_LATENCY=1. Writes commit from the latched copies in WRITE.
  assign sram_we   = (state == ST_WRITE) && !oor_q;
  assign sram_en   = (accept && !mem_we) || sram_we;
  assign sram_addr = (state == ST_IDLE) ? word_idx[IDX_W-1:0] : idx_q;

  npu_sram_1rw #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mem_mem_ready <= 1'b0;
      mem_rdata     <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      oor_q         <= 1'b0;
      lat_cnt       <= '0;
      is_wr_q       <= 1'b0;
    end else begin
      mem_mem_ready <= 1'b0;

      // A new error outranks a clear arriving in the same cycle.
      if (err_event) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_q   <= word_idx[IDX_W-1:0];
            wdata_q <= mem_wdata;
            oor_q   <= oor;
            is_wr_q <= mem_we;
            lat_cnt <= '0;
            busy    <= 1'b1;
            state   <= mem_we ? ST_WRITE : ST_READ_WAIT;
          end
        end
        ST_WRITE: begin
          mem_mem_ready <= 1'b1;
          state         <= ST_RESP;
        end
        ST_READ_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            mem_rdata     <= oor_q ? '0 : sram_rdata;
            mem_mem_ready <= 1'b1;
            state         <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_RESP: begin
          if (is_wr_q) begin
            wr_cnt_q <= sat_inc(wr_cnt_q);
          end else begin
            rd_cnt_q <= sat_inc(rd_cnt_q);
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_mem_responder.sv
// tb/tb_npu_mem_responder.sv - self-checking bench for npu_mem_responder
module tb_npu_mem_responder;

  localparam int          RL    = 2;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned BASE  = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_mem_ready;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  npu_mem_responder #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .DEPTH_WORDS  (DEPTH),
    .BASE_ADDR    (BASE),
    .READ_LATENCY (RL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .mem_mem_ready (mem_mem_ready),
    .busy          (busy),
    .err           (err),
    .err_clr       (err_clr),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word array, last read word, sticky error, counters.
  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_ok  [DEPTH];
  logic [31:0] exp_rdata;
  bit          exp_rdata_known;
  bit          exp_err;
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) / 4) >= DEPTH);
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", mem_mem_ready, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_wr_count", wr_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_rdata       = '0;
    exp_rdata_known = 1'b1;
    exp_err         = 1'b0;
    exp_rd          = '0;
    exp_wr          = '0;
  endtask

  // One complete transaction; called and returns on a falling edge.
  task automatic access(input bit we, input bit re, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit clr, input bit scramble);
    int          n;
    bit          seen;
    bit          bad;
    int unsigned w;
    bad       = out_of_range(addr);
    w         = bad ? 0 : (addr - BASE) / 4;
    mem_we    = we;
    mem_re    = re;
    mem_addr  = addr;
    mem_wdata = wdata;
    err_clr   = clr;
    n         = 0;
    seen      = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        err_clr = 1'b0;
        if (scramble) begin
          mem_addr  = $urandom;
          mem_wdata = $urandom;
        end
        check("busy_inflight", busy, 1);
      end
      if (mem_mem_ready) seen = 1'b1;
    end
    check(we ? "wr_latency" : "rd_latency", n, we ? 2 : RL + 1);

    if (clr) exp_err = 1'b0;
    if ((we && re) || (addr[1:0] != 2'b00) || bad) exp_err = 1'b1;
    if (we) begin
      if (!bad) begin
        mdl_mem[w] = wdata;
        mdl_ok[w]  = 1'b1;
      end
      exp_wr = sat16(exp_wr);
    end else begin
      exp_rdata       = bad ? 32'h0 : mdl_mem[w];
      exp_rdata_known = bad || mdl_ok[w];
      exp_rd          = sat16(exp_rd);
    end
    if (exp_rdata_known) check("rdata", mem_rdata, exp_rdata);
    check("err", err, exp_err);

    @(negedge clk);
    check("ready_one_cycle", mem_mem_ready, 0);
    check("busy_after", busy, 0);
    check("rd_count", rd_count, exp_rd);
    check("wr_count", wr_count, exp_wr);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_cleared", err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          pulses;
    int          n;
    int          last;
    logic [31:0] a;
    logic [31:0] keep;
    bit          w_e;
    bit          r_e;
    int          kind;
    int          sel;

    for (int i = 0; i < int'(DEPTH); i++) mdl_ok[i] = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    @(negedge clk);
    do_reset();

    // Basic write then read at 0x10.
    access(1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, 1'b0);
    access(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
    check("rd_cafef00d", mem_rdata, 32'hCAFEF00D);

    // Level-held burst read of word 0 over preloaded words 0..8.
    for (int i = 0; i < 9; i++) access(1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b1);
    mem_addr = 32'h0;
    mem_re   = 1'b1;
    pulses   = 0;
    n        = 0;
    last     = 0;
    while (pulses < 9 && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_mem_ready) begin
        pulses++;
        check("burst_rdata", mem_rdata, mdl_mem[0]);
        if (pulses > 1) check("burst_period", n - last, RL + 2);
        last = n;
        if (pulses == 9) mem_re = 1'b0;
      end
    end
    check("burst_pulses", pulses, 9);
    @(negedge clk);
    check("burst_end_ready", mem_mem_ready, 0);
    exp_rd    = exp_rd + 16'd9;
    exp_rdata = mdl_mem[0];
    check("burst_rd_count", rd_count, exp_rd);

    // Out-of-range read, then clearing the error.
    access(1'b0, 1'b1, 32'h1000, 32'h0, 1'b0, 1'b0);
    check("oor_rdata", mem_rdata, 0);
    check("oor_err", err, 1);
    clear_err();
    // Clear coinciding with a misaligned access: the error wins.
    access(1'b0, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0);
    check("clr_vs_event", err, 1);
    clear_err();

    // Simultaneous write and read from reset: write wins and flags err.
    do_reset();
    access(1'b1, 1'b1, 32'h4, 32'h55, 1'b0, 1'b0);
    check("both_err", err, 1);
    check("both_wr_count", wr_count, 1);
    check("both_rd_count", rd_count, 0);
    access(1'b0, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0);
    check("both_readback", mem_rdata, 32'h55);

    // Reset while in WRITE: nothing commits, no ready pulse.
    keep = $urandom;
    access(1'b1, 1'b0, 32'h20, keep, 1'b0, 1'b0);
    mem_we    = 1'b1;
    mem_addr  = 32'h20;
    mem_wdata = ~keep;
    @(negedge clk);
    mem_we = 1'b0;
    rst_n  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_mem_ready) pulses++;
    end
    check("rst_mid_no_ready", pulses, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_rd_count", rd_count, 0);
    check("rst_mid_wr_count", wr_count, 0);
    check("rst_mid_err", err, 0);
    exp_rdata = '0; exp_rdata_known = 1'b1; exp_err = 1'b0; exp_rd = '0; exp_wr = '0;
    access(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0);
    check("rst_mid_unchanged", mem_rdata, keep);

    // Randomized traffic over the first 64 words plus error addresses.
    for (int i = 0; i < 64; i++) access(1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b1);
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'h1000 + ($urandom & 32'h0FFF_FFFF);
      else                a = 32'($urandom_range(0, 63) * 4);
      sel = $urandom_range(0, 5);
      w_e = (sel <= 2);
      r_e = (sel == 0) || (sel >= 3);
      access(w_e, r_e, a, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
    end

    // Write counter saturation.
    do_reset();
    force dut.wr_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.wr_cnt_q;
    exp_wr = 16'hFFFE;
    for (int i = 0; i < 3; i++) access(1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b0);
    check("wr_count_sat", wr_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
